// File: rtl/ex2_stage_pkg.sv
// Shared encodings for the EX2 stage: MDU opcodes, FSM states, datapath width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex2_stage_pkg;

  localparam int WIDTH      = 16;
  localparam int MDU_CYCLES = 16;
  localparam int RD_W       = 4;

  typedef enum logic [1:0] {
    MDU_NONE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIVU = 2'd2,
    MDU_REMU = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ex2_state_e;

  // Control half of the EX1/EX2 pipeline register.
  typedef struct packed {
    logic    valid;
    logic    zero;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    is_branch;
    logic    branch_ne;
    mdu_op_e mdu_op;
  } ex2_ctrl_t;

  function automatic logic is_mdu(input mdu_op_e op);
    return op != MDU_NONE;
  endfunction

endpackage

// File: rtl/ex2_stage_mdu_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// Latency: MDU_CYCLES cycles from start; result valid the cycle after done.
// Backpressure: none; start is only accepted by the parent when the unit is not busy.
module mdu_iter
  import ex2_stage_pkg::*;
#(
  parameter int WIDTH      = ex2_stage_pkg::WIDTH,
  parameter int MDU_CYCLES = ex2_stage_pkg::MDU_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_CYCLES - 1);

  mdu_op_e          op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  // a_q: multiplicand (shifts for MUL) or dividend copy (static for DIV/REM)
  logic [WIDTH-1:0] a_q;
  // b_q: multiplier (shifts for MUL) or divisor (static for DIV/REM)
  logic [WIDTH-1:0] b_q;
  // acc_q: product accumulator for MUL, partial remainder for DIV/REM
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] quo_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             div_by_zero;

  // One restoring-division step: shift in next dividend bit, try to subtract.
  always_comb begin
    rem_sh   = {acc_q, quo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
  end

  // Iteration datapath and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= MDU_NONE;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      quo_q  <= '0;
    end else if (start) begin
      op_q   <= op;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      a_q    <= a;
      b_q    <= b;
      acc_q  <= '0;
      quo_q  <= a;
    end else if (busy_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        busy_q <= 1'b0;
      end
      if (op_q == MDU_MUL) begin
        if (b_q[0]) begin
          acc_q <= acc_q + a_q;
        end
        a_q <= a_q << 1;
        b_q <= b_q >> 1;
      end else begin
        if (!rem_diff[WIDTH]) begin
          acc_q <= rem_diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_q <= rem_sh[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign busy        = busy_q;
  assign done        = busy_q & (cnt_q == CNT_LAST);
  assign div_by_zero = (b_q == '0);

  // Result select; divide by zero is pinned to all-ones quotient / dividend remainder.
  always_comb begin
    result = '0;
    case (op_q)
      MDU_MUL:  result = acc_q;
      MDU_DIVU: result = div_by_zero ? {WIDTH{1'b1}} : quo_q;
      MDU_REMU: result = div_by_zero ? a_q : acc_q;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex2_stage.sv
// Second execute stage: EX1/EX2 pipeline register, branch resolution, iterative MDU control.
// Latency: 1 cycle for ALU ops; MDU_CYCLES+1 cycles for MUL/DIVU/REMU.
// Backpressure: stall_o holds upstream and blocks capture while the MDU iterates.
module ex2_stage
  import ex2_stage_pkg::*;
#(
  parameter int WIDTH      = ex2_stage_pkg::WIDTH,
  // Must equal WIDTH: the divider retires one dividend bit per iteration.
  parameter int MDU_CYCLES = ex2_stage_pkg::MDU_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             ex1_valid,
  input  logic [WIDTH-1:0] ex1_alu_result,
  input  logic             ex1_zero,
  input  logic [WIDTH-1:0] ex1_branch_target,
  input  logic [RD_W-1:0]  ex1_rd,
  input  logic [WIDTH-1:0] ex1_op_a,
  input  logic [WIDTH-1:0] ex1_op_b,
  input  logic             ex1_reg_write,
  input  logic             ex1_mem_read,
  input  logic             ex1_mem_write,
  input  logic             ex1_is_branch,
  input  logic             ex1_branch_ne,
  input  logic [1:0]       ex1_mdu_op,
  output logic [WIDTH-1:0] ex2_alu_result,
  output logic [RD_W-1:0]  ex2_rd,
  output logic             ex2_reg_write,
  output logic             ex2_mem_read,
  output logic             ex2_mem_write,
  output logic [WIDTH-1:0] ex2_store_data,
  output logic             ex2_fwd_valid,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_target_out,
  output logic             flush_o,
  output logic             stall_o
);

  ex2_ctrl_t        ctrl_q;
  logic [WIDTH-1:0] alu_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] store_q;
  logic [RD_W-1:0]  rd_q;

  ex2_state_e       state_q;
  logic             stall_q;

  mdu_op_e          ex1_op;
  logic             capture;
  logic             live_in;
  logic             mdu_start;
  logic             mdu_busy;
  logic             mdu_done;
  logic [WIDTH-1:0] mdu_result;

  assign ex1_op    = mdu_op_e'(ex1_mdu_op);
  assign capture   = ~stall_q;
  assign live_in   = ex1_valid & ~flush_i;
  assign mdu_start = capture & live_in & is_mdu(ex1_op);

  // EX1/EX2 pipeline register; a flushed or invalid capture becomes a non-MDU bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      alu_q    <= '0;
      target_q <= '0;
      store_q  <= '0;
      rd_q     <= '0;
    end else if (capture) begin
      ctrl_q.valid     <= live_in;
      ctrl_q.zero      <= ex1_zero;
      ctrl_q.reg_write <= ex1_reg_write;
      ctrl_q.mem_read  <= ex1_mem_read;
      ctrl_q.mem_write <= ex1_mem_write;
      ctrl_q.is_branch <= ex1_is_branch;
      ctrl_q.branch_ne <= ex1_branch_ne;
      ctrl_q.mdu_op    <= live_in ? ex1_op : MDU_NONE;
      alu_q            <= ex1_alu_result;
      target_q         <= ex1_branch_target;
      store_q          <= ex1_op_b;
      rd_q             <= ex1_rd;
    end
  end

  // MDU sequencing FSM; stall is registered and high exactly while in BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stall_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu_start) begin
            state_q <= BUSY;
            stall_q <= 1'b1;
          end
        end
        BUSY: begin
          if (mdu_done) begin
            state_q <= DONE;
            stall_q <= 1'b0;
          end
        end
        DONE: begin
          if (mdu_start) begin
            state_q <= BUSY;
            stall_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  mdu_iter #(
    .WIDTH      (WIDTH),
    .MDU_CYCLES (MDU_CYCLES)
  ) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_start),
    .op     (ex1_op),
    .a      (ex1_op_a),
    .b      (ex1_op_b),
    .busy   (mdu_busy),
    .done   (mdu_done),
    .result (mdu_result)
  );

  // Output qualification; mdu_busy tracks the BUSY state cycle for cycle.
  always_comb begin
    ex2_alu_result    = is_mdu(ctrl_q.mdu_op) ? mdu_result : alu_q;
    ex2_rd            = rd_q;
    ex2_reg_write     = ctrl_q.valid & ctrl_q.reg_write & ~mdu_busy;
    ex2_mem_read      = ctrl_q.valid & ctrl_q.mem_read;
    ex2_mem_write     = ctrl_q.valid & ctrl_q.mem_write;
    ex2_store_data    = store_q;
    ex2_fwd_valid     = ex2_reg_write & (rd_q != '0);
    branch_taken      = ctrl_q.valid & ctrl_q.is_branch & (ctrl_q.zero ^ ctrl_q.branch_ne);
    branch_target_out = target_q;
    flush_o           = branch_taken;
    stall_o           = stall_q;
  end

endmodule

// File: tb/tb_ex2_stage.sv
// Directed bench for ex2_stage: ALU passthrough, MDU ops, branches, flush, reset.
// Latency: checks 1-cycle ALU and 17-cycle MDU result timing.
// Backpressure: checks stall_o duration and capture at the end of DONE.
module tb_ex2_stage;
  import ex2_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        ex1_valid;
  logic [15:0] ex1_alu_result;
  logic        ex1_zero;
  logic [15:0] ex1_branch_target;
  logic [3:0]  ex1_rd;
  logic [15:0] ex1_op_a;
  logic [15:0] ex1_op_b;
  logic        ex1_reg_write;
  logic        ex1_mem_read;
  logic        ex1_mem_write;
  logic        ex1_is_branch;
  logic        ex1_branch_ne;
  logic [1:0]  ex1_mdu_op;
  logic [15:0] ex2_alu_result;
  logic [3:0]  ex2_rd;
  logic        ex2_reg_write;
  logic        ex2_mem_read;
  logic        ex2_mem_write;
  logic [15:0] ex2_store_data;
  logic        ex2_fwd_valid;
  logic        branch_taken;
  logic [15:0] branch_target_out;
  logic        flush_o;
  logic        stall_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex2_stage dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .ex1_valid         (ex1_valid),
    .ex1_alu_result    (ex1_alu_result),
    .ex1_zero          (ex1_zero),
    .ex1_branch_target (ex1_branch_target),
    .ex1_rd            (ex1_rd),
    .ex1_op_a          (ex1_op_a),
    .ex1_op_b          (ex1_op_b),
    .ex1_reg_write     (ex1_reg_write),
    .ex1_mem_read      (ex1_mem_read),
    .ex1_mem_write     (ex1_mem_write),
    .ex1_is_branch     (ex1_is_branch),
    .ex1_branch_ne     (ex1_branch_ne),
    .ex1_mdu_op        (ex1_mdu_op),
    .ex2_alu_result    (ex2_alu_result),
    .ex2_rd            (ex2_rd),
    .ex2_reg_write     (ex2_reg_write),
    .ex2_mem_read      (ex2_mem_read),
    .ex2_mem_write     (ex2_mem_write),
    .ex2_store_data    (ex2_store_data),
    .ex2_fwd_valid     (ex2_fwd_valid),
    .branch_taken      (branch_taken),
    .branch_target_out (branch_target_out),
    .flush_o           (flush_o),
    .stall_o           (stall_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush_i           = 1'b0;
    ex1_valid         = 1'b0;
    ex1_alu_result    = '0;
    ex1_zero          = 1'b0;
    ex1_branch_target = '0;
    ex1_rd            = '0;
    ex1_op_a          = '0;
    ex1_op_b          = '0;
    ex1_reg_write     = 1'b0;
    ex1_mem_read      = 1'b0;
    ex1_mem_write     = 1'b0;
    ex1_is_branch     = 1'b0;
    ex1_branch_ne     = 1'b0;
    ex1_mdu_op        = 2'b00;
  endtask

  task automatic drive_alu(input logic [15:0] res, input logic [3:0] rd, input logic rw);
    drive_idle();
    ex1_valid      = 1'b1;
    ex1_alu_result = res;
    ex1_rd         = rd;
    ex1_reg_write  = rw;
  endtask

  task automatic drive_mdu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] rd);
    drive_idle();
    ex1_valid     = 1'b1;
    ex1_mdu_op    = op;
    ex1_op_a      = a;
    ex1_op_b      = b;
    ex1_rd        = rd;
    ex1_reg_write = 1'b1;
  endtask

  task automatic drive_branch(input logic zero, input logic ne, input logic [15:0] tgt);
    drive_idle();
    ex1_valid         = 1'b1;
    ex1_is_branch     = 1'b1;
    ex1_branch_ne     = ne;
    ex1_zero          = zero;
    ex1_branch_target = tgt;
  endtask

  // Called one cycle after an MDU capture; returns in the DONE cycle.
  task automatic wait_mdu(input string tag, input logic [15:0] exp);
    int n;
    int bad_fwd;
    int bad_rw;
    n = 0;
    bad_fwd = 0;
    bad_rw = 0;
    while (stall_o === 1'b1 && n < 40) begin
      if (ex2_fwd_valid !== 1'b0) bad_fwd++;
      if (ex2_reg_write !== 1'b0) bad_rw++;
      tick();
      n++;
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'd16);
    chk({tag, "_busy_fwd"}, 32'(bad_fwd), 32'd0);
    chk({tag, "_busy_rw"}, 32'(bad_rw), 32'd0);
    chk({tag, "_result"}, 32'(ex2_alu_result), 32'(exp));
    chk({tag, "_done_rw"}, 32'(ex2_reg_write), 32'd1);
    chk({tag, "_done_fwd"}, 32'(ex2_fwd_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (2) tick();
    chk("rst_result", 32'(ex2_alu_result), 32'h0);
    chk("rst_reg_write", 32'(ex2_reg_write), 32'h0);
    chk("rst_fwd", 32'(ex2_fwd_valid), 32'h0);
    chk("rst_taken", 32'(branch_taken), 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_target", 32'(branch_target_out), 32'h0);
    rst = 1'b0;

    // ALU passthrough
    drive_alu(16'h00A5, 4'd3, 1'b1);
    tick();
    chk("add_result", 32'(ex2_alu_result), 32'h00A5);
    chk("add_rd", 32'(ex2_rd), 32'd3);
    chk("add_fwd", 32'(ex2_fwd_valid), 32'd1);
    chk("add_stall", 32'(stall_o), 32'd0);

    // Store: mem_write and store data, no register write
    drive_idle();
    ex1_valid     = 1'b1;
    ex1_mem_write = 1'b1;
    ex1_op_b      = 16'hBEEF;
    tick();
    chk("st_mem_write", 32'(ex2_mem_write), 32'd1);
    chk("st_data", 32'(ex2_store_data), 32'hBEEF);
    chk("st_fwd", 32'(ex2_fwd_valid), 32'd0);

    // Load to r0: reg_write passes through but never forwards
    drive_alu(16'h1111, 4'd0, 1'b1);
    ex1_mem_read = 1'b1;
    tick();
    chk("ld_mem_read", 32'(ex2_mem_read), 32'd1);
    chk("ld_r0_rw", 32'(ex2_reg_write), 32'd1);
    chk("ld_r0_fwd", 32'(ex2_fwd_valid), 32'd0);

    // MUL, then an ADD waiting upstream that is captured at the end of DONE
    drive_mdu(2'b01, 16'h0123, 16'h0010, 4'd5);
    tick();
    drive_alu(16'h0077, 4'd6, 1'b1);
    wait_mdu("mul", 16'h1230);
    tick();
    chk("mul_next_result", 32'(ex2_alu_result), 32'h0077);
    chk("mul_next_rd", 32'(ex2_rd), 32'd6);

    // DIVU then REMU back to back
    drive_mdu(2'b10, 16'd100, 16'd7, 4'd7);
    tick();
    drive_mdu(2'b11, 16'd100, 16'd7, 4'd8);
    wait_mdu("divu", 16'h000E);
    tick();
    chk("b2b_stall", 32'(stall_o), 32'd1);
    chk("b2b_rd", 32'(ex2_rd), 32'd8);
    drive_idle();
    wait_mdu("remu", 16'h0002);

    // Divide by zero
    drive_mdu(2'b10, 16'h1234, 16'h0000, 4'd9);
    tick();
    drive_mdu(2'b11, 16'h1234, 16'h0000, 4'd10);
    wait_mdu("div0", 16'hFFFF);
    tick();
    drive_idle();
    wait_mdu("rem0", 16'h1234);
    tick();
    chk("idle_after_mdu_stall", 32'(stall_o), 32'd0);

    // BEQ taken; flush_i does not disturb the branch already held
    drive_branch(1'b1, 1'b0, 16'h0040);
    tick();
    chk("beq_taken", 32'(branch_taken), 32'd1);
    chk("beq_flush_o", 32'(flush_o), 32'd1);
    chk("beq_target", 32'(branch_target_out), 32'h0040);
    drive_alu(16'h5555, 4'd2, 1'b1);
    flush_i = 1'b1;
    #1;
    chk("beq_hold_under_flush", 32'(branch_taken), 32'd1);
    tick();
    chk("bubble_taken", 32'(branch_taken), 32'd0);
    chk("bubble_rw", 32'(ex2_reg_write), 32'd0);
    chk("bubble_fwd", 32'(ex2_fwd_valid), 32'd0);

    // BEQ not taken
    drive_branch(1'b0, 1'b0, 16'h0080);
    tick();
    chk("beq_nt", 32'(branch_taken), 32'd0);
    chk("beq_nt_flush_o", 32'(flush_o), 32'd0);

    // BNE taken
    drive_branch(1'b0, 1'b1, 16'h00C0);
    tick();
    chk("bne_taken", 32'(branch_taken), 32'd1);
    chk("bne_target", 32'(branch_target_out), 32'h00C0);

    // Reset in the middle of a MUL at cnt=5
    drive_mdu(2'b01, 16'h00FF, 16'h00FF, 4'd4);
    tick();
    drive_idle();
    repeat (5) tick();
    chk("mid_mul_stall", 32'(stall_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(stall_o), 32'd0);
    chk("rst_mid_result", 32'(ex2_alu_result), 32'h0);
    chk("rst_mid_rd", 32'(ex2_rd), 32'h0);
    chk("rst_mid_rw", 32'(ex2_reg_write), 32'h0);
    tick();
    rst = 1'b0;
    drive_alu(16'h0C0C, 4'd9, 1'b1);
    tick();
    chk("post_rst_stall", 32'(stall_o), 32'd0);
    chk("post_rst_result", 32'(ex2_alu_result), 32'h0C0C);
    chk("post_rst_fwd", 32'(ex2_fwd_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
